// File: rtl/jt89_pkg.sv
// Shared constants and LFSR step function for the jt89 noise channel.
// The step function is also used by the verification model.
package jt89_pkg;

    localparam int unsigned W_TI  = 15;
    localparam int unsigned W_SMS = 16;

    localparam logic [15:0] SEED_TI  = 16'h4000;
    localparam logic [15:0] SEED_SMS = 16'h8000;

    localparam int unsigned TAP_TI  = 1;
    localparam int unsigned TAP_SMS = 3;

    localparam int unsigned CTRL_WHITE_BIT = 2;

    typedef enum logic [1:0] {
        RATE_16    = 2'd0,
        RATE_32    = 2'd1,
        RATE_64    = 2'd2,
        RATE_TONE2 = 2'd3
    } rate_e;

    // Counter reload for a given rate; RATE_TONE2 shares the slowest reload.
    function automatic logic [6:0] reload_for(input rate_e rate);
        logic [6:0] r;
        case (rate)
            RATE_16: r = 7'd15;
            RATE_32: r = 7'd31;
            default: r = 7'd63;
        endcase
        return r;
    endfunction

    // One LFSR shift. Operates on a 16-bit container; for the TI variant the
    // register occupies bits 14:0 and bit 15 is returned as zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr,
                                              input logic        white,
                                              input logic        sms);
        logic fb;
        if (sms) begin
            fb = lfsr[0] ^ (white & lfsr[TAP_SMS]);
            return {fb, lfsr[15:1]};
        end else begin
            fb = lfsr[0] ^ (white & lfsr[TAP_TI]);
            return {1'b0, fb, lfsr[14:1]};
        end
    endfunction

endpackage

// File: rtl/jt89_noise.sv
// SN76489-family noise channel: LFSR clocked by a fixed tick divider or by
// rising edges of tone channel 2.
module jt89_noise
    import jt89_pkg::*;
#(
    parameter int SMS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       clr,
    input  logic [2:0] ctrl3,
    input  logic       tone2,
    output logic       out
);

    localparam int unsigned W    = (SMS != 0) ? W_SMS : W_TI;
    localparam logic [W-1:0] SEED = W'((SMS != 0) ? SEED_SMS : SEED_TI);

    logic [W-1:0] lfsr_q, lfsr_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         ff_q, ff_d;
    logic         t2_last_q, t2_last_d;

    rate_e        rate;
    logic         white;

    always_comb begin
        rate      = rate_e'(ctrl3[1:0]);
        white     = ctrl3[CTRL_WHITE_BIT];
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        ff_d      = ff_q;
        t2_last_d = t2_last_q;
        if (clr) begin
            lfsr_d    = SEED;
            cnt_d     = reload_for(rate);
            ff_d      = 1'b0;
            t2_last_d = tone2;
        end else if (clk_en) begin
            t2_last_d = tone2;
            if (rate == RATE_TONE2) begin
                if (tone2 && !t2_last_q)
                    lfsr_d = W'(lfsr_step(16'(lfsr_q), white, SMS != 0));
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 7'd1;
            end else begin
                // Divider reload toggles ff; only the 0->1 edge shifts.
                cnt_d = reload_for(rate);
                ff_d  = ~ff_q;
                if (!ff_q)
                    lfsr_d = W'(lfsr_step(16'(lfsr_q), white, SMS != 0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q    <= SEED;
            cnt_q     <= 7'd15;
            ff_q      <= 1'b0;
            t2_last_q <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            ff_q      <= ff_d;
            t2_last_q <= t2_last_d;
        end
    end

    assign out = lfsr_q[0];

endmodule

// File: tb/tb_jt89_noise.sv
// Directed bench for jt89_noise; both LFSR variants run side by side.
module tb_jt89_noise;
    import jt89_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] ctrl3 = 3'b000;
    logic       tone2 = 1'b0;
    logic       out0, out1;

    always #5 clk = ~clk;

    jt89_noise #(.SMS(0)) dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .clr(clr),
        .ctrl3(ctrl3), .tone2(tone2), .out(out0)
    );

    jt89_noise #(.SMS(1)) dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .clr(clr),
        .ctrl3(ctrl3), .tone2(tone2), .out(out1)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] m0, m1;
    int unsigned tk, first, per;
    logic        white;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference shift.
    function automatic logic [15:0] ref_step(input logic [15:0] v, input logic w, input logic sms);
        logic fb;
        if (sms) begin
            fb = v[0] ^ (w & v[3]);
            return {fb, v[15:1]};
        end
        fb = v[0] ^ (w & v[1]);
        return {1'b0, fb, v[14:1]};
    endfunction

    task automatic cyc(input logic en, input logic c, input logic r);
        clk_en = en;
        clr    = c;
        rst    = r;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        clr    = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic seed_model();
        m0 = 16'h4000;
        m1 = 16'h8000;
        tk = 0;
    endtask

    task automatic cmp(input string tag);
        check({tag, "_o0"}, 32'(out0), 32'(m0[0]));
        check({tag, "_o1"}, 32'(out1), 32'(m1[0]));
    endtask

    task automatic run(input int unsigned n, input int unsigned gap, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            tk++;
            if (tk >= first && ((tk - first) % per) == 0) begin
                m0 = ref_step(m0, white, 1'b0);
                m1 = ref_step(m1, white, 1'b1);
            end
            cmp(tag);
            for (int unsigned g = 0; g < gap; g++) begin
                cyc(1'b0, 1'b0, 1'b0);
                cmp({tag, "_stall"});
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        int unsigned n;
        logic        prev;

        // T1: reset, periodic rate 0
        ctrl3 = 3'b000;
        white = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        check("rst_o0", 32'(out0), 32'd0);
        check("rst_o1", 32'(out1), 32'd0);
        seed_model();
        first = 16;
        per   = 32;
        run(431, 0, "t1");
        check("t1_pre431", 32'(out0), 32'd0);
        run(1, 0, "t1");
        check("t1_on432", 32'(out0), 32'd1);
        run(31, 0, "t1");
        check("t1_hold463", 32'(out0), 32'd1);
        run(1, 0, "t1");
        check("t1_off464", 32'(out0), 32'd0);
        run(447, 0, "t1");
        check("t1_pre911", 32'(out0), 32'd0);
        run(1, 0, "t1");
        check("t1_again912", 32'(out0), 32'd1);

        // T2/T3: white rate 0, both variants against the reference
        ctrl3 = 3'b100;
        white = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        seed_model();
        check("t2_clr_o0", 32'(out0), 32'd0);
        run(300 * 32, 0, "t2");

        // Full-period check of the shared step function
        v = SEED_TI;
        n = 0;
        do begin
            v = lfsr_step(v, 1'b1, 1'b0);
            n++;
        end while (v != SEED_TI && n < 70000);
        check("period_ti", n, 32'd32767);
        v = SEED_SMS;
        n = 0;
        do begin
            v = lfsr_step(v, 1'b1, 1'b1);
            n++;
        end while (v != SEED_SMS && n < 70000);
        check("period_sms", n, 32'd57337);

        // T4: follow tone 2
        ctrl3 = 3'b011;
        white = 1'b0;
        tone2 = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        seed_model();
        prev = 1'b0;
        for (int unsigned i = 0; i < 140; i++) begin
            tone2 = ((i / 5) % 2) == 1;
            cyc(1'b1, 1'b0, 1'b0);
            if (tone2 && !prev) begin
                m0 = ref_step(m0, 1'b0, 1'b0);
                m1 = ref_step(m1, 1'b0, 1'b1);
            end
            prev = tone2;
            cmp("t4_edges");
        end
        check("t4_14th_o0", 32'(out0), 32'd1);
        tone2 = 1'b1;
        for (int unsigned i = 0; i < 1000; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cmp("t4_hold");
        end
        // Counter stayed at its rate-3 reload (63): first shift 64 ticks on
        tone2 = 1'b0;
        ctrl3 = 3'b000;
        tk    = 0;
        first = 64;
        per   = 32;
        run(63, 0, "t4_frozen");
        check("t4_pre64_o0", 32'(out0), 32'd1);
        run(1, 0, "t4_frozen");
        check("t4_at64_o0", 32'(out0), 32'd0);
        run(136, 0, "t4_after");

        // T5: clr coinciding with a shift tick
        ctrl3 = 3'b100;
        white = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        seed_model();
        first = 16;
        per   = 32;
        run(655, 0, "t5_pre");
        cyc(1'b1, 1'b1, 1'b0);
        seed_model();
        check("t5_clr_o0", 32'(out0), 32'd0);
        check("t5_clr_o1", 32'(out1), 32'd0);
        run(400, 0, "t5_post");

        // T6: rate 1, clk_en 1-in-3, reset mid-run
        ctrl3 = 3'b001;
        white = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        seed_model();
        first = 32;
        per   = 64;
        run(863, 2, "t6");
        check("t6_pre864_o0", 32'(out0), 32'd0);
        run(1, 2, "t6");
        check("t6_on864_o0", 32'(out0), 32'd1);
        run(36, 2, "t6");
        cyc(1'b0, 1'b0, 1'b1);
        check("t6_rst_o0", 32'(out0), 32'd0);
        check("t6_rst_o1", 32'(out1), 32'd0);
        seed_model();
        first = 16;
        per   = 64;
        run(900, 2, "t6_rst");
        check("t6_rst848_o0", 32'(out0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
